// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl
//
// Sequencer for the 3x3 PE-array convolution top. For each frame it clears the
// row FIFOs, loads the nine kernel weights and streams the input feature map in
// raster order. It generates every array strobe and forwards only valid-window
// convolution results on a valid-qualified output stream.
//
// Build option:
//   CONV_SEQ_CTRL_RELU_EN  when defined, negative results (MSB set) are replaced
//                          by zero. When undefined, results pass through
//                          unmodified. out_valid timing is the same in both builds.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i             begin one frame (sampled in IDLE only)
//   abort_i             drop the current frame and return to IDLE
//   wgt_in_i            nine packed weights, w0 in the MSBs (sampled in LOAD_WGT)
//   in_data_i/valid_i   pixel stream from host/DMA
//   in_ready_o          high only while streaming
//   ifm_o, wgt_o        pixel and weight buses to the array
//   set_wgt_o/set_ifm_o/set_reg_o  array strobes
//   wr_en_k_o, rd_en_k_o            row FIFO enables, k = 0..2
//   rd_clr_o, wr_clr_o  FIFO pointer clear
//   data_output_i       array result
//   out_data_o/valid_o  registered result, one pulse per valid window
//   busy_o              frame in progress
//   done_o              one-cycle pulse at frame end
module conv_seq_ctrl #(
  parameter int unsigned IFM_WIDTH    = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned IMG_W        = 7,
  parameter int unsigned IMG_H        = 7,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [9*WEIGHT_WIDTH-1:0] wgt_in_i,
  input  logic [IFM_WIDTH-1:0]      in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [IFM_WIDTH-1:0]      ifm_o,
  output logic [9*WEIGHT_WIDTH-1:0] wgt_o,
  output logic                      set_wgt_o,
  output logic                      set_ifm_o,
  output logic                      set_reg_o,
  output logic                      wr_en_0_o,
  output logic                      wr_en_1_o,
  output logic                      wr_en_2_o,
  output logic                      rd_en_0_o,
  output logic                      rd_en_1_o,
  output logic                      rd_en_2_o,
  output logic                      rd_clr_o,
  output logic                      wr_clr_o,
  input  logic [DATA_WIDTH-1:0]     data_output_i,
  output logic [DATA_WIDTH-1:0]     out_data_o,
  output logic                      out_valid_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam logic [CNT_WIDTH-1:0] ColLast  = CNT_WIDTH'(IMG_W - 1);
  localparam logic [CNT_WIDTH-1:0] RowLast  = CNT_WIDTH'(IMG_H - 1);
  localparam logic [CNT_WIDTH-1:0] WinFirst = CNT_WIDTH'(KERNEL_SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoadWgt,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Raster position of the next pixel to be accepted.
  logic [CNT_WIDTH-1:0] col_q, col_d;
  logic [CNT_WIDTH-1:0] row_q, row_d;

  // Stage 1: pixel presented to the array with set_ifm.
  logic                 s1_valid_q, s1_valid_d;
  logic [IFM_WIDTH-1:0] ifm_q, ifm_d;
  logic [CNT_WIDTH-1:0] s1_row_q, s1_row_d;
  logic [CNT_WIDTH-1:0] s1_col_q, s1_col_d;

  // Stage 2: set_reg / FIFO enables; the (row, col) tag rides along.
  logic                 s2_valid_q, s2_valid_d;
  logic [CNT_WIDTH-1:0] s2_row_q, s2_row_d;
  logic [CNT_WIDTH-1:0] s2_col_q, s2_col_d;
  logic [2:0]           rd_en_q, rd_en_d;

  // Output stage.
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  // Kernel register and its strobe launch together so the array sees a stable
  // weight bus in the same cycle set_wgt is high.
  logic                      set_wgt_q, set_wgt_d;
  logic [9*WEIGHT_WIDTH-1:0] wgt_q, wgt_d;

  logic                  beat;
  logic                  last_beat;
  logic                  flush;
  logic                  win_ok;
  logic [DATA_WIDTH-1:0] result;

  // abort is only meaningful outside IDLE; it empties the pipeline at the next edge.
  assign flush     = abort_i & (state_q != StIdle);
  assign beat      = in_ready_o & in_valid_i;
  assign last_beat = beat & (col_q == ColLast) & (row_q == RowLast);
  assign win_ok    = (s2_row_q >= WinFirst) & (s2_col_q >= WinFirst);

`ifdef CONV_SEQ_CTRL_RELU_EN
  assign result = data_output_i[DATA_WIDTH-1] ? '0 : data_output_i;
`else
  assign result = data_output_i;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM and raster counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StClear;
      end
      StClear: begin
        col_d   = '0;
        row_d   = '0;
        state_d = StLoadWgt;
      end
      StLoadWgt: begin
        state_d = StStream;
      end
      StStream: begin
        if (beat) begin
          if (col_q == ColLast) begin
            col_d = '0;
            row_d = row_q + CNT_WIDTH'(1);
          end else begin
            col_d = col_q + CNT_WIDTH'(1);
          end
          if (last_beat) state_d = StDrain;
        end
      end
      StDrain: begin
        // With S1 and S2 empty the output stage is in its final cycle now.
        if (!s1_valid_q && !s2_valid_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat pipeline: S1 -> S2 -> output
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = beat & ~flush;
    ifm_d      = ifm_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;
    if (beat && !flush) begin
      ifm_d    = in_data_i;
      s1_row_d = row_q;
      s1_col_d = col_q;
    end

    s2_valid_d = s1_valid_q & ~flush;
    s2_row_d   = s2_row_q;
    s2_col_d   = s2_col_q;
    if (s1_valid_q) begin
      s2_row_d = s1_row_q;
      s2_col_d = s1_col_q;
    end
    // FIFO k only holds data once row k+1 has started arriving.
    for (int unsigned k = 0; k < 3; k++) begin
      rd_en_d[k] = s1_valid_q & ~flush & (s1_row_q >= CNT_WIDTH'(k + 1));
    end

    out_valid_d = s2_valid_q & win_ok & ~flush;
    out_data_d  = out_valid_d ? result : out_data_q;

    set_wgt_d = (state_q == StLoadWgt) & ~flush;
    wgt_d     = set_wgt_d ? wgt_in_i : wgt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      ifm_q       <= '0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_row_q    <= '0;
      s2_col_q    <= '0;
      rd_en_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      set_wgt_q   <= 1'b0;
      wgt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      ifm_q       <= ifm_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s2_valid_q  <= s2_valid_d;
      s2_row_q    <= s2_row_d;
      s2_col_q    <= s2_col_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      set_wgt_q   <= set_wgt_d;
      wgt_q       <= wgt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready_o  = (state_q == StStream);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);
  assign rd_clr_o    = (state_q == StClear);
  assign wr_clr_o    = (state_q == StClear);

  assign ifm_o       = ifm_q;
  assign wgt_o       = wgt_q;
  assign set_wgt_o   = set_wgt_q;
  assign set_ifm_o   = s1_valid_q;
  assign set_reg_o   = s2_valid_q;
  assign wr_en_0_o   = s2_valid_q;
  assign wr_en_1_o   = s2_valid_q;
  assign wr_en_2_o   = s2_valid_q;
  assign rd_en_0_o   = rd_en_q[0];
  assign rd_en_1_o   = rd_en_q[1];
  assign rd_en_2_o   = rd_en_q[2];

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule
